// File: rtl/hdb3_decoder.sv
// HDB3 two-rail to NRZ decoder with V-detection, substitution removal and line-code error flags.
// Latency 3 symbol clocks to o_data; no backpressure, one symbol accepted on every i_clk edge.
module hdb3_decoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_p,
  input  logic                 i_n,
  input  logic                 i_cnt_clr,
  output logic                 o_data,
  output logic [2:0]           o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  logic       have_pol, last_pol;
  logic       have_v, last_v_pol;
  logic [3:0] sr;
  logic [2:0] run_cnt;

  logic       sym_pos, sym_neg, sym_ill, sym_pulse, sym_pol;
  logic       is_v, is_mark;
  logic       have_pol_nxt, last_pol_nxt, have_v_nxt, last_v_pol_nxt;
  logic [3:0] sr_nxt;
  logic [2:0] run_cnt_nxt;
  logic [2:0] err_nxt;
  logic [ERR_CNT_W-1:0] cnt_nxt;

  // Polarity encoding: 1 = positive pulse, 0 = negative pulse.
  assign sym_pos   = i_p & ~i_n;
  assign sym_neg   = i_n & ~i_p;
  assign sym_ill   = i_p & i_n;
  assign sym_pulse = sym_pos | sym_neg;
  assign sym_pol   = sym_pos;

  assign is_v    = sym_pulse & have_pol & (sym_pol == last_pol);
  assign is_mark = sym_pulse & ~is_v;

  always_comb begin
    have_pol_nxt   = have_pol;
    last_pol_nxt   = last_pol;
    have_v_nxt     = have_v;
    last_v_pol_nxt = last_v_pol;
    sr_nxt         = {sr[2:0], is_mark};
    run_cnt_nxt    = run_cnt;
    err_nxt        = 3'b000;
    cnt_nxt        = o_err_cnt;

    if (sym_pulse) begin
      have_pol_nxt = 1'b1;
      last_pol_nxt = sym_pol;
    end

    // A V zeroes itself and the three symbols before it, covering both 000V and B00V.
    if (is_v) begin
      sr_nxt         = 4'b0000;
      have_v_nxt     = 1'b1;
      last_v_pol_nxt = sym_pol;
      if (have_v && (sym_pol == last_v_pol))
        err_nxt[1] = 1'b1;
    end

    if (sym_pulse) begin
      run_cnt_nxt = 3'd0;
    end else if (have_pol) begin
      if (run_cnt != 3'd7)
        run_cnt_nxt = run_cnt + 3'd1;
      if (run_cnt == 3'd3)
        err_nxt[2] = 1'b1;
    end

    err_nxt[0] = sym_ill;

    if (i_cnt_clr)
      cnt_nxt = '0;
    else if ((|err_nxt) && (o_err_cnt != {ERR_CNT_W{1'b1}}))
      cnt_nxt = o_err_cnt + ERR_CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      have_pol   <= 1'b0;
      last_pol   <= 1'b0;
      have_v     <= 1'b0;
      last_v_pol <= 1'b0;
      sr         <= 4'b0000;
      run_cnt    <= 3'd0;
      o_err      <= 3'b000;
      o_err_cnt  <= '0;
    end else begin
      have_pol   <= have_pol_nxt;
      last_pol   <= last_pol_nxt;
      have_v     <= have_v_nxt;
      last_v_pol <= last_v_pol_nxt;
      sr         <= sr_nxt;
      run_cnt    <= run_cnt_nxt;
      o_err      <= err_nxt;
      o_err_cnt  <= cnt_nxt;
    end
  end

  assign o_data = sr[3];

endmodule

// File: tb/tb_hdb3_decoder.sv
// Directed bench for hdb3_decoder: marks, substitutions, error flags, counter and a modelled-encoder loopback.
module tb_hdb3_decoder;

  localparam int W    = 4;
  localparam int LB_N = 160;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_p = 1'b0;
  logic         i_n = 1'b0;
  logic         i_cnt_clr = 1'b0;
  logic         o_data;
  logic [2:0]   o_err;
  logic [W-1:0] o_err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  hdb3_decoder #(.ERR_CNT_W(W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_p       (i_p),
    .i_n       (i_n),
    .i_cnt_clr (i_cnt_clr),
    .o_data    (o_data),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic drive(input logic [1:0] s);
    {i_p, i_n} = s;
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n   = 1'b0;
    {i_p, i_n} = 2'b00;
    i_cnt_clr = 1'b0;
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    n_assert++;
    if (o_data !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %b want 0", o_data); end
    n_assert++;
    if (o_err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", o_err); end
    n_assert++;
    if (o_err_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", o_err_cnt); end
    n_assert++;
    if ({dut.have_pol, dut.have_v, dut.run_cnt, dut.sr} !== 9'b0)
      begin n_fail++; $display("FAIL reset_state: got %b want 0", {dut.have_pol, dut.have_v, dut.run_cnt, dut.sr}); end
    i_rst_n = 1'b1;
  endtask

  task automatic test_marks();
    logic [1:0] sym [7] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    apply_reset();
    for (int j = 0; j < 7; j++) begin
      drive(sym[j]);
      n_assert++;
      if (o_data !== 1'(j >= 3)) begin n_fail++; $display("FAIL marks_data[%0d]: got %b want %b", j, o_data, j >= 3); end
      n_assert++;
      if (o_err !== 3'b000) begin n_fail++; $display("FAIL marks_err[%0d]: got %b want 000", j, o_err); end
    end
  endtask

  task automatic test_000v();
    logic [1:0] sym [8] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    apply_reset();
    for (int j = 0; j < 8; j++) begin
      drive(sym[j]);
      n_assert++;
      if (o_data !== 1'(j == 3)) begin n_fail++; $display("FAIL 000v_data[%0d]: got %b want %b", j, o_data, j == 3); end
      n_assert++;
      if (o_err !== 3'b000) begin n_fail++; $display("FAIL 000v_err[%0d]: got %b want 000", j, o_err); end
    end
    n_assert++;
    if ({dut.have_v, dut.last_v_pol} !== 2'b11)
      begin n_fail++; $display("FAIL 000v_vstate: got %b want 11", {dut.have_v, dut.last_v_pol}); end
  endtask

  task automatic test_b00v();
    logic [1:0] sym [8] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    apply_reset();
    for (int j = 0; j < 8; j++) begin
      drive(sym[j]);
      n_assert++;
      if (o_data !== 1'(j == 3)) begin n_fail++; $display("FAIL b00v_data[%0d]: got %b want %b", j, o_data, j == 3); end
      n_assert++;
      if (o_err !== 3'b000) begin n_fail++; $display("FAIL b00v_err[%0d]: got %b want 000", j, o_err); end
    end
  endtask

  task automatic test_vpol_err();
    logic [1:0] sym [12] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00,
                             2'b10, 2'b00, 2'b00, 2'b00};
    apply_reset();
    for (int j = 0; j < 12; j++) begin
      drive(sym[j]);
      n_assert++;
      if (o_data !== 1'(j == 3)) begin n_fail++; $display("FAIL vpol_data[%0d]: got %b want %b", j, o_data, j == 3); end
      n_assert++;
      if (o_err !== ((j == 8) ? 3'b010 : 3'b000))
        begin n_fail++; $display("FAIL vpol_err[%0d]: got %b want %b", j, o_err, (j == 8) ? 3'b010 : 3'b000); end
    end
    n_assert++;
    if (o_err_cnt !== W'(1)) begin n_fail++; $display("FAIL vpol_cnt: got %0d want 1", o_err_cnt); end
  endtask

  task automatic test_code_run_cnt();
    logic [1:0] sym [7] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [2:0] exp_err;
    apply_reset();
    for (int j = 0; j < 7; j++) begin
      drive(sym[j]);
      exp_err = (j == 1) ? 3'b001 : (j == 4) ? 3'b100 : 3'b000;
      n_assert++;
      if (o_err !== exp_err) begin n_fail++; $display("FAIL code_run_err[%0d]: got %b want %b", j, o_err, exp_err); end
      n_assert++;
      if (o_data !== 1'(j == 3)) begin n_fail++; $display("FAIL code_run_data[%0d]: got %b want %b", j, o_data, j == 3); end
    end
    n_assert++;
    if (o_err_cnt !== W'(2)) begin n_fail++; $display("FAIL code_run_cnt: got %0d want 2", o_err_cnt); end
    // Clear wins over a simultaneous code error.
    i_cnt_clr = 1'b1;
    drive(2'b11);
    i_cnt_clr = 1'b0;
    n_assert++;
    if (o_err_cnt !== W'(0)) begin n_fail++; $display("FAIL cnt_clr: got %0d want 0", o_err_cnt); end
    n_assert++;
    if (o_err !== 3'b001) begin n_fail++; $display("FAIL cnt_clr_err: got %b want 001", o_err); end
    for (int j = 1; j <= 20; j++) begin
      drive(2'b11);
      if (j == 14) begin
        n_assert++;
        if (o_err_cnt !== W'(14)) begin n_fail++; $display("FAIL cnt_ramp: got %0d want 14", o_err_cnt); end
      end
      if (j == 20) begin
        n_assert++;
        if (o_err_cnt !== {W{1'b1}}) begin n_fail++; $display("FAIL cnt_sat: got %0d want %0d", o_err_cnt, {W{1'b1}}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] sym [4] = '{2'b10, 2'b00, 2'b00, 2'b00};
    apply_reset();
    drive(2'b10);
    drive(2'b01);
    drive(2'b10);
    drive(2'b11);
    #2;
    i_rst_n = 1'b0;
    #1;
    n_assert++;
    if ({o_err, dut.sr, dut.have_pol} !== 8'b0)
      begin n_fail++; $display("FAIL mid_reset_clear: got %b want 0", {o_err, dut.sr, dut.have_pol}); end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    // After release, a positive pulse must be a mark even though the last pulse before reset was positive.
    for (int j = 0; j < 4; j++) begin
      drive(sym[j]);
      n_assert++;
      if (o_err !== 3'b000) begin n_fail++; $display("FAIL mid_reset_err[%0d]: got %b want 000", j, o_err); end
    end
    n_assert++;
    if (o_data !== 1'b1) begin n_fail++; $display("FAIL mid_reset_mark: got %b want 1", o_data); end
  endtask

  task automatic test_loopback();
    logic       d [LB_N];
    logic [1:0] r [LB_N];
    logic       pol;
    int         marks;
    int         idx;
    int         i;
    int         len;
    d[0] = 1'b1;
    idx  = 1;
    while (idx < LB_N - 1) begin
      if ($urandom_range(3) == 0) begin
        len = int'($urandom_range(12, 4));
        for (int k = 0; k < len && idx < LB_N - 1; k++) begin
          d[idx] = 1'b0;
          idx++;
        end
      end else begin
        d[idx] = 1'($urandom_range(1));
        idx++;
      end
    end
    d[LB_N-1] = 1'b1;

    // Reference HDB3 encoding: alternate marks, substitute each run of four zeros.
    pol   = 1'b0;
    marks = 0;
    i     = 0;
    while (i < LB_N) begin
      if (i + 3 < LB_N && !d[i] && !d[i+1] && !d[i+2] && !d[i+3]) begin
        r[i+1] = 2'b00;
        r[i+2] = 2'b00;
        if (marks % 2 == 1) begin
          r[i] = 2'b00;
        end else begin
          pol  = ~pol;
          r[i] = pol ? 2'b10 : 2'b01;
        end
        r[i+3] = pol ? 2'b10 : 2'b01;
        marks  = 0;
        i     += 4;
      end else if (d[i]) begin
        pol  = ~pol;
        r[i] = pol ? 2'b10 : 2'b01;
        marks++;
        i++;
      end else begin
        r[i] = 2'b00;
        i++;
      end
    end

    apply_reset();
    for (int j = 0; j < LB_N + 3; j++) begin
      drive((j < LB_N) ? r[j] : 2'b00);
      if (j >= 3) begin
        n_assert++;
        if (o_data !== d[j-3]) begin n_fail++; $display("FAIL loop_data[%0d]: got %b want %b", j - 3, o_data, d[j-3]); end
      end
      n_assert++;
      if (o_err !== 3'b000) begin n_fail++; $display("FAIL loop_err[%0d]: got %b want 000", j, o_err); end
    end
  endtask

  initial begin
    test_reset();
    test_marks();
    test_000v();
    test_b00v();
    test_vpol_err();
    test_code_run_cnt();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
